// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
package perf_mon_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_LOOP    = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_e;

    // Consecutive matches needed before a period-p loop is declared.
    function automatic int unsigned thr(input int unsigned p, input int unsigned mult,
                                        input int unsigned min_match);
        return (mult * p > min_match) ? mult * p : min_match;
    endfunction

endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// IF/ID observation tap: the datapath drives it, the monitor listens.
interface pipeline_perf_monitor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic            stall_i;

    modport master (output pc_i, instr_i, stall_i);
    modport slave  (input  pc_i, instr_i, stall_i);
endinterface

// File: rtl/perf_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, start/busy/done handshake with abort.
module perf_seq_divider #(
    parameter int NW = 40,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [NW-1:0] quotient_o
);
    localparam int CW = $clog2(NW + 1);

    logic [DW-1:0] rem_q;
    logic [DW-1:0] dvsr_q;
    logic [NW-1:0] quot_q;
    logic [CW-1:0] cnt_q;
    logic [DW:0]   trial;
    logic          ge;

    // Remainder stays below the divisor, so DW bits hold it between steps.
    assign trial      = {rem_q, quot_q[NW-1]};
    assign ge         = trial >= {1'b0, dvsr_q};
    assign quotient_o = quot_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || abort_i) begin
            rem_q  <= '0;
            dvsr_q <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i && !busy_o) begin
                rem_q  <= '0;
                dvsr_q <= divisor_i;
                quot_q <= dividend_i;
                cnt_q  <= CW'(NW);
                busy_o <= 1'b1;
            end else if (busy_o) begin
                rem_q  <= ge ? DW'(trial - {1'b0, dvsr_q}) : trial[DW-1:0];
                quot_q <= {quot_q[NW-2:0], ge};
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pipeline_perf_monitor.sv
// Run-control and performance monitor beside the 5-stage pipeline: counters, halt-loop and timeout detection.
// Build option: define PERF_MON_CPI_EN to add the post-run CPI (Q8.8) divider outputs.
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int CNT_W          = 32,
    parameter int MAX_PERIOD     = 8,
    parameter int MATCH_MULT     = 2,
    parameter int MIN_MATCH      = 3,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             clear,
    pipeline_perf_monitor_if.slave           mon,
    output logic                             running,
    output logic                             done,
    output logic [1:0]                       done_cause,
    output logic [$clog2(MAX_PERIOD+1)-1:0]  loop_period,
    output logic [XLEN-1:0]                  loop_pc,
    output logic [CNT_W-1:0]                 cycle_count,
    output logic [CNT_W-1:0]                 instr_count,
    output logic [CNT_W-1:0]                 stall_count
`ifdef PERF_MON_CPI_EN
    ,
    output logic [15:0]                      cpi_q8,
    output logic                             cpi_valid
`endif
);
    localparam int PW      = $clog2(MAX_PERIOD + 1);
    localparam int THR_MAX = thr(MAX_PERIOD, MATCH_MULT, MIN_MATCH);
    localparam int MW      = $clog2(THR_MAX + 1);

    state_e          state_q;
    cause_e          cause_q;
    logic            done_q;
    logic [PW-1:0]   period_q, hv_q, hit_p;
    logic [XLEN-1:0] loop_pc_q, prev_instr_q;
    logic [XLEN-1:0] hist_q [MAX_PERIOD];
    logic [MW-1:0]   mc_q   [MAX_PERIOD];
    logic [MW-1:0]   mc_d   [MAX_PERIOD];
    logic [CNT_W-1:0] cycle_q, instr_q, stall_q, cycle_d;
    logic            hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cycle_d = sat_inc(cycle_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hit   = 1'b0;
        hit_p = '0;
        for (int p = 1; p <= MAX_PERIOD; p++) begin
            mc_d[p-1] = '0;
            if (hv_q >= PW'(p) && mon.pc_i == hist_q[p-1] &&
                (p != 1 || mon.instr_i == prev_instr_q))
                mc_d[p-1] = mc_q[p-1] + 1'b1;
            if (!hit && mc_d[p-1] == MW'(thr(p, MATCH_MULT, MIN_MATCH))) begin
                hit   = 1'b1;
                hit_p = PW'(p);
            end
        end
    end

    // NOTE: history and match counters are wiped explicitly so no stale PC can fake a loop after clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;  cause_q <= CAUSE_NONE;  done_q <= 1'b0;
            period_q <= '0;   loop_pc_q <= '0;        hv_q <= '0;  prev_instr_q <= '0;
            cycle_q <= '0;    instr_q <= '0;          stall_q <= '0;
            for (int i = 0; i < MAX_PERIOD; i++) begin
                hist_q[i] <= '0;
                mc_q[i]   <= '0;
            end
        end else if (clear) begin
            state_q <= IDLE;  cause_q <= CAUSE_NONE;  done_q <= 1'b0;
            period_q <= '0;   loop_pc_q <= '0;        hv_q <= '0;  prev_instr_q <= '0;
            cycle_q <= '0;    instr_q <= '0;          stall_q <= '0;
            for (int i = 0; i < MAX_PERIOD; i++) begin
                hist_q[i] <= '0;
                mc_q[i]   <= '0;
            end
        end else begin
            // NOTE: state uses <= so every register here sees its peers' pre-edge values.
            case (state_q)
                IDLE: if (enable) state_q <= RUN;
                RUN: begin
                    cycle_q <= cycle_d;
                    if (mon.stall_i)
                        stall_q <= sat_inc(stall_q);
                    else if (mon.instr_i != XLEN'(NOP_INSTR))
                        instr_q <= sat_inc(instr_q);
                    if (!mon.stall_i) begin
                        hist_q[0]    <= mon.pc_i;
                        for (int i = 1; i < MAX_PERIOD; i++) hist_q[i] <= hist_q[i-1];
                        prev_instr_q <= mon.instr_i;
                        if (hv_q != PW'(MAX_PERIOD)) hv_q <= hv_q + 1'b1;
                        for (int i = 0; i < MAX_PERIOD; i++) mc_q[i] <= mc_d[i];
                    end
                    if (!mon.stall_i && hit) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        cause_q   <= CAUSE_LOOP;
                        period_q  <= hit_p;
                        loop_pc_q <= mon.pc_i;
                    end else if (cycle_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        cause_q   <= CAUSE_TIMEOUT;
                        period_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign running     = (state_q == RUN);
    assign done        = done_q;
    assign done_cause  = cause_q;
    assign loop_period = period_q;
    assign loop_pc     = loop_pc_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
    assign stall_count = stall_q;

`ifdef PERF_MON_CPI_EN
    localparam int NW = CNT_W + 8;

    logic          div_start, div_busy, div_done, cpi_started_q, cpi_valid_q;
    logic [NW-1:0] div_quot;
    logic [15:0]   cpi_q8_q;

    // Counters are frozen in DONE, so the divider may sample them any time after entry.
    assign div_start = (state_q == DONE) && !cpi_started_q && !div_busy;

    perf_seq_divider #(.NW(NW), .DW(CNT_W)) u_div (
        .clk_i      (clock),
        .rst_i      (reset),
        .abort_i    (clear),
        .start_i    (div_start),
        .dividend_i ({cycle_q, 8'h00}),
        .divisor_i  (instr_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpi_started_q <= 1'b0;
            cpi_valid_q   <= 1'b0;
            cpi_q8_q      <= '0;
        end else if (clear) begin
            cpi_started_q <= 1'b0;
            cpi_valid_q   <= 1'b0;
            cpi_q8_q      <= '0;
        end else begin
            if (div_start) cpi_started_q <= 1'b1;
            if (div_done) begin
                cpi_valid_q <= 1'b1;
                cpi_q8_q    <= (instr_q == '0 || |div_quot[NW-1:16]) ? 16'hFFFF : div_quot[15:0];
            end
        end
    end

    assign cpi_q8    = cpi_q8_q;
    assign cpi_valid = cpi_valid_q;
`endif
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor: directed scenarios plus randomized runs against a sample-history model.
module tb_pipeline_perf_monitor;
    localparam int XLEN           = 32;
    localparam int CNT_W          = 32;
    localparam int MAX_PERIOD     = 8;
    localparam int MATCH_MULT     = 2;
    localparam int MIN_MATCH      = 3;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int PW             = $clog2(MAX_PERIOD + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset, enable, clear;
    pipeline_perf_monitor_if #(.XLEN(XLEN)) mon_if ();

    logic             running, done;
    logic [1:0]       done_cause;
    logic [PW-1:0]    loop_period;
    logic [XLEN-1:0]  loop_pc;
    logic [CNT_W-1:0] cycle_count, instr_count, stall_count;
`ifdef PERF_MON_CPI_EN
    logic [15:0]      cpi_q8;
    logic             cpi_valid;
`endif

    int errors = 0;
    int checks = 0;

    pipeline_perf_monitor #(
        .XLEN(XLEN), .CNT_W(CNT_W), .MAX_PERIOD(MAX_PERIOD), .MATCH_MULT(MATCH_MULT),
        .MIN_MATCH(MIN_MATCH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear), .mon(mon_if.slave),
        .running(running), .done(done), .done_cause(done_cause), .loop_period(loop_period),
        .loop_pc(loop_pc), .cycle_count(cycle_count), .instr_count(instr_count),
        .stall_count(stall_count)
`ifdef PERF_MON_CPI_EN
        , .cpi_q8(cpi_q8), .cpi_valid(cpi_valid)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: the run is a list of non-stalled samples; loops are found by scanning it.
    bit          m_running, m_done;
    int unsigned m_cause, m_period, m_cyc, m_ins, m_stl;
    logic [31:0] m_loop_pc;
    logic [31:0] s_pc[$];
    logic [31:0] s_in[$];

    task automatic model_zero();
        m_running = 0; m_done = 0; m_cause = 0; m_period = 0; m_loop_pc = '0;
        m_cyc = 0; m_ins = 0; m_stl = 0;
        s_pc.delete(); s_in.delete();
    endtask

    function automatic int unsigned need(input int unsigned p);
        return (MATCH_MULT * p > MIN_MATCH) ? MATCH_MULT * p : MIN_MATCH;
    endfunction

    function automatic int unsigned run_len(input int p);
        int k = s_pc.size() - 1;
        int unsigned n = 0;
        while (k >= p && s_pc[k] == s_pc[k-p] && (p != 1 || s_in[k] == s_in[k-1])) begin
            n++;
            k--;
        end
        return n;
    endfunction

    task automatic model_edge();
        int unsigned hit_p = 0;
        if (reset || clear) begin
            model_zero();
        end else if (!m_running && !m_done) begin
            if (enable) m_running = 1;
        end else if (m_running) begin
            m_cyc++;
            if (mon_if.stall_i) m_stl++;
            else if (mon_if.instr_i != NOP) m_ins++;
            if (!mon_if.stall_i) begin
                s_pc.push_back(mon_if.pc_i);
                s_in.push_back(mon_if.instr_i);
                for (int p = 1; p <= MAX_PERIOD; p++)
                    if (hit_p == 0 && run_len(p) == need(p)) hit_p = p;
            end
            if (hit_p != 0) begin
                m_running = 0; m_done = 1; m_cause = 1; m_period = hit_p; m_loop_pc = mon_if.pc_i;
            end else if (m_cyc == TIMEOUT_CYCLES) begin
                m_running = 0; m_done = 1; m_cause = 2; m_period = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic st);
        mon_if.pc_i = pc; mon_if.instr_i = ins; mon_if.stall_i = st;
    endtask

    task automatic start_run();
        enable = 1'b1; tick(); enable = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; drive('0, '0, 1'b0);
        model_zero();
        #3;
        checks++; if ({running, done, done_cause, loop_period} !== '0) begin errors++;
            $display("FAIL reset_flags: got %0h expected 0", {running, done, done_cause, loop_period}); end
        checks++; if ({cycle_count, instr_count, stall_count, loop_pc} !== '0) begin errors++;
            $display("FAIL reset_counters: got %0h expected 0", {cycle_count, instr_count, stall_count, loop_pc}); end
        enable = 1'b1; tick(); enable = 1'b0;
        checks++; if (running !== 1'b0) begin errors++;
            $display("FAIL reset_holds_idle: running=%0b expected 0", running); end
        reset = 1'b0;
        tick();
        checks++; if (running !== 1'b0 || cycle_count !== '0) begin errors++;
            $display("FAIL idle_no_count: running=%0b cycles=%0d expected 0/0", running, cycle_count); end
    endtask

    task automatic test_loop_period1();
        do_clear(); start_run();
        drive(32'h28, 32'h0000_006F, 1'b0);
        repeat (3) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL p1_early: done=%0b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1 || done_cause !== 2'd1) begin errors++;
            $display("FAIL p1_done: done=%0b cause=%0d expected 1/1", done, done_cause); end
        checks++; if (loop_period !== PW'(1) || loop_pc !== 32'h28) begin errors++;
            $display("FAIL p1_loop: period=%0d pc=%0h expected 1/28", loop_period, loop_pc); end
        checks++; if (cycle_count !== 32'd4 || running !== 1'b0) begin errors++;
            $display("FAIL p1_state: cycles=%0d running=%0b expected 4/0", cycle_count, running); end
    endtask

    task automatic test_loop_period2();
        do_clear(); start_run();
        for (int i = 0; i < 6; i++) begin
            drive((i % 2) ? 32'h34 : 32'h30, (i % 2) ? 32'h0020_8233 : 32'h0010_8133, 1'b0);
            tick();
            if (i == 4) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL p2_early: done=%0b expected 0", done); end
            end
        end
        checks++; if (done !== 1'b1 || done_cause !== 2'd1) begin errors++;
            $display("FAIL p2_done: done=%0b cause=%0d expected 1/1", done, done_cause); end
        checks++; if (loop_period !== PW'(2) || loop_pc !== 32'h34) begin errors++;
            $display("FAIL p2_loop: period=%0d pc=%0h expected 2/34", loop_period, loop_pc); end
    endtask

    task automatic test_stall();
        do_clear(); start_run();
        drive(32'h40, 32'h33, 1'b1);
        repeat (10) tick();
        for (int i = 1; i <= 3; i++) begin drive(32'h40 + 32'(4 * i), 32'h33, 1'b0); tick(); end
        checks++; if (done !== 1'b0 || running !== 1'b1) begin errors++;
            $display("FAIL stall_state: done=%0b running=%0b expected 0/1", done, running); end
        checks++; if (stall_count !== 32'd10 || instr_count !== 32'd3 || cycle_count !== 32'd13) begin errors++;
            $display("FAIL stall_counts: stall=%0d instr=%0d cycle=%0d expected 10/3/13",
                     stall_count, instr_count, cycle_count); end
    endtask

    task automatic test_nop();
        do_clear(); start_run();
        for (int i = 0; i < 10; i++) begin
            drive(32'h100 + 32'(4 * i), (i % 2 == 0) ? NOP : 32'h00A0_0093, 1'b0);
            tick();
        end
        checks++; if (instr_count !== 32'd5 || cycle_count !== 32'd10 || done !== 1'b0) begin errors++;
            $display("FAIL nop_counts: instr=%0d cycle=%0d done=%0b expected 5/10/0",
                     instr_count, cycle_count, done); end
    endtask

    task automatic test_timeout();
        do_clear(); start_run();
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin drive(32'h200 + 32'(4 * i), 32'h93, 1'b0); tick(); end
        checks++; if (done !== 1'b0 || cycle_count !== 32'(TIMEOUT_CYCLES - 1)) begin errors++;
            $display("FAIL to_early: done=%0b cycle=%0d expected 0/%0d", done, cycle_count, TIMEOUT_CYCLES - 1); end
        drive(32'h600, 32'h93, 1'b0); tick();
        checks++; if (done !== 1'b1 || done_cause !== 2'd2 || loop_period !== '0) begin errors++;
            $display("FAIL to_done: done=%0b cause=%0d period=%0d expected 1/2/0", done, done_cause, loop_period); end
        checks++; if (cycle_count !== 32'(TIMEOUT_CYCLES)) begin errors++;
            $display("FAIL to_cycles: got %0d expected %0d", cycle_count, TIMEOUT_CYCLES); end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin drive(32'h700 + 32'(4 * i), 32'h93, 1'b0); tick(); end
        enable = 1'b0;
        checks++; if (cycle_count !== 32'(TIMEOUT_CYCLES) || instr_count !== 32'(TIMEOUT_CYCLES) ||
                      running !== 1'b0 || done !== 1'b1) begin errors++;
            $display("FAIL to_frozen: cycle=%0d instr=%0d running=%0b done=%0b expected %0d/%0d/0/1",
                     cycle_count, instr_count, running, done, TIMEOUT_CYCLES, TIMEOUT_CYCLES); end
    endtask

    task automatic test_reset_mid_run();
        do_clear(); start_run();
        for (int i = 0; i < 20; i++) begin drive(32'h800 + 32'(4 * i), 32'h93, i % 3 == 0); tick(); end
        @(negedge clock); reset = 1'b1; model_zero(); #1;
        checks++; if ({cycle_count, instr_count, stall_count} !== '0 || running !== 1'b0) begin errors++;
            $display("FAIL midrst_zero: cycle=%0d instr=%0d stall=%0d running=%0b expected 0",
                     cycle_count, instr_count, stall_count, running); end
        @(negedge clock); reset = 1'b0;
        repeat (5) tick();
        checks++; if (cycle_count !== '0 || running !== 1'b0) begin errors++;
            $display("FAIL midrst_idle: cycle=%0d running=%0b expected 0/0", cycle_count, running); end
        start_run(); tick();
        checks++; if (cycle_count !== 32'd1 || running !== 1'b1) begin errors++;
            $display("FAIL midrst_restart: cycle=%0d running=%0b expected 1/1", cycle_count, running); end
    endtask

    task automatic test_cpi();
        do_clear(); start_run();
        drive(32'h0FFC, 32'h93, 1'b1); repeat (4) tick();
        for (int i = 0; i < 16; i++) begin
            drive(32'h1000 + 32'(4 * i), 32'h93, 1'b0); tick();
            drive(32'h1000 + 32'(4 * i), 32'h93, 1'b1); tick();
        end
        drive(32'h28, 32'h6F, 1'b0); repeat (4) tick();
        checks++; if (done !== 1'b1 || loop_period !== PW'(1) || cycle_count !== 32'd40 ||
                      instr_count !== 32'd20 || stall_count !== 32'd20) begin errors++;
            $display("FAIL cpi_run: done=%0b period=%0d cycle=%0d instr=%0d stall=%0d expected 1/1/40/20/20",
                     done, loop_period, cycle_count, instr_count, stall_count); end
`ifdef PERF_MON_CPI_EN
        for (int w = 0; w < 200 && cpi_valid !== 1'b1; w++) tick();
        checks++; if (cpi_valid !== 1'b1 || cpi_q8 !== 16'h0200) begin errors++;
            $display("FAIL cpi_value: valid=%0b q8=%0h expected 1/0200", cpi_valid, cpi_q8); end
        do_clear();
        checks++; if (cpi_valid !== 1'b0 || cpi_q8 !== 16'h0000) begin errors++;
            $display("FAIL cpi_clear: valid=%0b q8=%0h expected 0/0", cpi_valid, cpi_q8); end
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int unsigned per, len, idx;
            logic [31:0] base, pc, ins;
            logic        st;
            per  = $urandom_range(1, MAX_PERIOD);
            len  = $urandom_range(20, 70);
            idx  = 0;
            base = 32'h4000 + 32'($urandom_range(0, 255)) * 32'h40;
            do_clear(); start_run();
            for (int c = 0; c < int'(len); c++) begin
                st  = ($urandom_range(0, 3) == 0);
                pc  = ($urandom_range(0, 15) == 0) ? base + 32'h800 + 32'($urandom_range(0, 7)) * 4
                                                    : base + 32'(idx % per) * 4;
                ins = ($urandom_range(0, 9) == 0) ? NOP : {pc[15:0], 16'h0093};
                if (!st) idx++;
                clear = ($urandom_range(0, 199) == 0);
                drive(pc, ins, st); tick(); clear = 1'b0;
                checks++; if (running !== m_running) begin errors++;
                    $display("FAIL rnd_running r%0d c%0d: got %0b expected %0b", r, c, running, m_running); end
                checks++; if (done !== m_done) begin errors++;
                    $display("FAIL rnd_done r%0d c%0d: got %0b expected %0b", r, c, done, m_done); end
                checks++; if (done_cause !== 2'(m_cause)) begin errors++;
                    $display("FAIL rnd_cause r%0d c%0d: got %0d expected %0d", r, c, done_cause, m_cause); end
                checks++; if (loop_period !== PW'(m_period)) begin errors++;
                    $display("FAIL rnd_period r%0d c%0d: got %0d expected %0d", r, c, loop_period, m_period); end
                checks++; if (loop_pc !== m_loop_pc) begin errors++;
                    $display("FAIL rnd_loop_pc r%0d c%0d: got %0h expected %0h", r, c, loop_pc, m_loop_pc); end
                checks++; if (cycle_count !== 32'(m_cyc)) begin errors++;
                    $display("FAIL rnd_cycles r%0d c%0d: got %0d expected %0d", r, c, cycle_count, m_cyc); end
                checks++; if (instr_count !== 32'(m_ins)) begin errors++;
                    $display("FAIL rnd_instrs r%0d c%0d: got %0d expected %0d", r, c, instr_count, m_ins); end
                checks++; if (stall_count !== 32'(m_stl)) begin errors++;
                    $display("FAIL rnd_stalls r%0d c%0d: got %0d expected %0d", r, c, stall_count, m_stl); end
            end
`ifdef PERF_MON_CPI_EN
            if (m_done) begin
                longint unsigned q;
                q = (m_ins == 0) ? 64'hFFFF : (longint'(m_cyc) * 256) / longint'(m_ins);
                if (q > 64'hFFFF) q = 64'hFFFF;
                for (int w = 0; w < 200 && cpi_valid !== 1'b1; w++) tick();
                checks++; if (cpi_valid !== 1'b1 || cpi_q8 !== 16'(q)) begin errors++;
                    $display("FAIL rnd_cpi r%0d: valid=%0b q8=%0h expected 1/%0h", r, cpi_valid, cpi_q8, q); end
            end
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loop_period1();
        test_loop_period2();
        test_stall();
        test_nop();
        test_timeout();
        test_reset_mid_run();
        test_cpi();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
